// File: rtl/clk_div_monitor.sv
// clk_div_monitor: syncs a divided clock, strobes its edges, measures period/high time, tracks lock (duty check via CLK_MON_DUTY_CHECK_EN)
module clk_div_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int NOM_PERIOD  = 25,
    parameter int NOM_HIGH    = 12,
    parameter int TOL         = 1,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk_100mhz,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             err_clr,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int TO_INT = 2 * NOM_PERIOD;
    localparam logic [CNT_W-1:0] TIMEOUT = (TO_INT > (2 ** CNT_W) - 1) ? CNT_MAX : CNT_W'(TO_INT);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_COUNT - 1);
    localparam logic signed [CNT_W:0] NOM_P_S = (CNT_W+1)'(NOM_PERIOD);
    localparam logic signed [CNT_W:0] NOM_H_S = (CNT_W+1)'(NOM_HIGH);
    localparam logic signed [CNT_W:0] TOL_S   = (CNT_W+1)'(TOL);
`ifdef CLK_MON_DUTY_CHECK_EN
    localparam logic DUTY_EN = 1'b1;
`else
    localparam logic DUTY_EN = 1'b0;
`endif

    typedef enum logic {ACQ, LOCKED} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES:0]   fill;
    logic                   synced, hist, saw_low, armed, good_p;
    logic [CNT_W-1:0]       cnt;
    logic signed [CNT_W:0]  p_diff, h_diff;
    logic                   p_ok, h_ok, timeout, bad, hit, err_set;
    state_t                 state, next_state;
    logic [GW-1:0]          good_cnt, good_nx;

    assign synced = sync[SYNC_STAGES-1];
    assign locked = (state == LOCKED);

    always_comb begin
        p_diff  = $signed({1'b0, cnt}) - NOM_P_S;
        h_diff  = $signed({1'b0, high_time}) - NOM_H_S;
        p_ok    = (p_diff <= TOL_S) && (p_diff >= -TOL_S);
        h_ok    = (h_diff <= TOL_S) && (h_diff >= -TOL_S);
        timeout = (cnt == TIMEOUT) && !rise_stb;
    end

    // A rise only counts once a post-reset low has been seen, so a clock already high at release is ignored
    always_ff @(posedge clk_100mhz) begin
        if (!reset) begin
            sync         <= '0;
            fill         <= '0;
            hist         <= 1'b0;
            saw_low      <= 1'b0;
            rise_stb     <= 1'b0;
            fall_stb     <= 1'b0;
            cnt          <= '0;
            armed        <= 1'b0;
            period_valid <= 1'b0;
            period       <= '0;
            high_time    <= '0;
            good_p       <= 1'b0;
        end else begin
            sync         <= {sync[SYNC_STAGES-2:0], clk_in};
            fill         <= {fill[SYNC_STAGES-1:0], 1'b1};
            hist         <= synced;
            saw_low      <= saw_low | (fill[SYNC_STAGES] & ~synced);
            rise_stb     <= synced & ~hist & saw_low;
            fall_stb     <= ~synced & hist;
            cnt          <= rise_stb ? CNT_W'(1) : (cnt == CNT_MAX ? cnt : cnt + 1'b1);
            armed        <= armed | rise_stb;
            period_valid <= rise_stb & armed;
            if (rise_stb && armed) begin
                period <= cnt;
                good_p <= p_ok & (h_ok | ~DUTY_EN);
            end
            if (fall_stb && armed)
                high_time <= cnt;
        end
    end

    always_comb begin
        bad        = timeout | (period_valid & ~good_p);
        hit        = period_valid & good_p & (good_cnt == LOCK_LAST) & ~bad;
        next_state = (state == ACQ) ? (hit ? LOCKED : ACQ) : (bad ? ACQ : LOCKED);
        good_nx    = (bad || hit || state == LOCKED) ? '0 : (period_valid ? good_cnt + 1'b1 : good_cnt);
        err_set    = (state == LOCKED) & bad;
    end

    always_ff @(posedge clk_100mhz) begin
        if (!reset) begin
            state    <= ACQ;
            good_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= next_state;
            good_cnt <= good_nx;
            err      <= err_set | (err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed checks of edge strobes, period/high-time measurement, lock, timeout and reset
module tb_clk_div_monitor;
    logic       clk_100mhz = 1'b0;
    logic       reset = 1'b0;
    logic       clk_in = 1'b0;
    logic       err_clr = 1'b0;
    logic       rise_stb, fall_stb, period_valid, locked, err;
    logic [7:0] period, high_time;

    int vectors = 0, miscompares = 0;
    int pv_cnt = 0, rise_cnt = 0, stb_err = 0;
    logic prev_r = 1'b0, prev_f = 1'b0;
`ifdef CLK_MON_DUTY_CHECK_EN
    localparam logic DUTY_EXP_LOCK = 1'b0;
`else
    localparam logic DUTY_EXP_LOCK = 1'b1;
`endif

    always #5 clk_100mhz = ~clk_100mhz;

    clk_div_monitor dut (
        .clk_100mhz  (clk_100mhz),
        .reset       (reset),
        .clk_in      (clk_in),
        .err_clr     (err_clr),
        .rise_stb    (rise_stb),
        .fall_stb    (fall_stb),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .locked      (locked),
        .err         (err)
    );

    always @(negedge clk_100mhz) begin
        if (period_valid) pv_cnt <= pv_cnt + 1;
        if (rise_stb) rise_cnt <= rise_cnt + 1;
        if ((rise_stb && fall_stb) || (rise_stb && prev_r) || (fall_stb && prev_f)) stb_err <= stb_err + 1;
        prev_r <= rise_stb;
        prev_f <= fall_stb;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_100mhz);
    endtask

    task automatic pulse(input int h, input int l);
        clk_in = 1'b1;
        cyc(h);
        clk_in = 1'b0;
        cyc(l);
    endtask

    task automatic test_reset;
        reset = 1'b0; clk_in = 1'b0; err_clr = 1'b0;
        cyc(3);
        vectors++;
        if ({rise_stb, fall_stb, period_valid, locked, err, period, high_time} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {rise_stb, fall_stb, period_valid, locked, err, period, high_time});
        end
        reset = 1'b1;
    endtask

    task automatic test_ideal;
        int pv0, r0;
        pv0 = pv_cnt; r0 = rise_cnt;
        cyc(4);
        pulse(12, 13);
        vectors++;
        if (pv_cnt - pv0 !== 0) begin miscompares++; $display("FAIL ideal_first_rise_arms: pv=%0d want 0", pv_cnt - pv0); end
        pulse(12, 13);
        vectors++;
        if (pv_cnt - pv0 !== 1) begin miscompares++; $display("FAIL ideal_pv_count: got %0d want 1", pv_cnt - pv0); end
        vectors++;
        if (period !== 8'd25) begin miscompares++; $display("FAIL ideal_period: got %0d want 25", period); end
        vectors++;
        if (high_time !== 8'd12) begin miscompares++; $display("FAIL ideal_high: got %0d want 12", high_time); end
        pulse(12, 13);
        pulse(12, 13);
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL ideal_early_lock: got %b want 0", locked); end
        pulse(12, 13);
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("FAIL ideal_lock: got %b want 1", locked); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL ideal_err: got %b want 0", err); end
        vectors++;
        if (rise_cnt - r0 !== 5) begin miscompares++; $display("FAIL ideal_rises: got %0d want 5", rise_cnt - r0); end
    endtask

    task automatic test_bad_period;
        pulse(12, 15);
        pulse(12, 13);
        vectors++;
        if (period !== 8'd27) begin miscompares++; $display("FAIL bad_period_val: got %0d want 27", period); end
        vectors++;
        if ({locked, err} !== 2'b01) begin miscompares++; $display("FAIL bad_unlock: locked/err=%b want 01", {locked, err}); end
        repeat (3) pulse(12, 13);
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL relock_early: got %b want 0", locked); end
        pulse(12, 13);
        vectors++;
        if ({locked, err} !== 2'b11) begin miscompares++; $display("FAIL relock: locked/err=%b want 11", {locked, err}); end
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL err_clr: got %b want 0", err); end
    endtask

    task automatic test_timeout;
        int pv0;
        pv0 = pv_cnt;
        cyc(19);
        vectors++;
        if ({locked, err} !== 2'b10) begin miscompares++; $display("FAIL stall_pre_timeout: locked/err=%b want 10", {locked, err}); end
        cyc(40);
        vectors++;
        if ({locked, err} !== 2'b01) begin miscompares++; $display("FAIL timeout: locked/err=%b want 01", {locked, err}); end
        vectors++;
        if (pv_cnt - pv0 !== 0) begin miscompares++; $display("FAIL stall_pv: got %0d want 0", pv_cnt - pv0); end
    endtask

    task automatic test_tolerance;
        pulse(12, 14);
        vectors++;
        if (period !== 8'd85) begin miscompares++; $display("FAIL stall_period: got %0d want 85", period); end
        pulse(12, 12);
        pulse(12, 14);
        pulse(12, 12);
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL tol_early_lock: got %b want 0", locked); end
        pulse(12, 14);
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("FAIL tol_lock: got %b want 1", locked); end
        pulse(12, 12);
        pulse(12, 13);
        vectors++;
        if (period !== 8'd24) begin miscompares++; $display("FAIL tol_period: got %0d want 24", period); end
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("FAIL tol_stay_locked: got %b want 1", locked); end
    endtask

    task automatic test_mid_reset;
        int r0;
        clk_in = 1'b1;
        cyc(5);
        reset = 1'b0;
        cyc(1);
        vectors++;
        if ({rise_stb, fall_stb, period_valid, locked, err, period, high_time} !== 21'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %h want 0", {rise_stb, fall_stb, period_valid, locked, err, period, high_time});
        end
        reset = 1'b1;
        r0 = rise_cnt;
        cyc(10);
        vectors++;
        if (rise_cnt - r0 !== 0) begin miscompares++; $display("FAIL high_at_release: rises=%0d want 0", rise_cnt - r0); end
        clk_in = 1'b0;
        cyc(13);
        pulse(12, 13);
        vectors++;
        if (rise_cnt - r0 !== 1) begin miscompares++; $display("FAIL first_real_rise: rises=%0d want 1", rise_cnt - r0); end
    endtask

    task automatic test_acq_restart;
        pulse(12, 13);
        pulse(12, 11);
        pulse(12, 13);
        vectors++;
        if (period !== 8'd23) begin miscompares++; $display("FAIL acq_bad_period: got %0d want 23", period); end
        repeat (3) pulse(12, 13);
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL acq_restart_lock: got %b want 0", locked); end
        pulse(12, 13);
        vectors++;
        if ({locked, err} !== 2'b10) begin miscompares++; $display("FAIL acq_relock: locked/err=%b want 10", {locked, err}); end
    endtask

    task automatic test_duty;
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(4);
        repeat (5) pulse(20, 5);
        vectors++;
        if (high_time !== 8'd20) begin miscompares++; $display("FAIL duty_high: got %0d want 20", high_time); end
        vectors++;
        if (locked !== DUTY_EXP_LOCK) begin miscompares++; $display("FAIL duty_lock: got %b want %b", locked, DUTY_EXP_LOCK); end
    endtask

    task automatic test_strobes;
        vectors++;
        if (stb_err !== 0) begin miscompares++; $display("FAIL strobe_shape: %0d bad strobe cycles want 0", stb_err); end
    endtask

    initial begin
        test_reset;
        test_ideal;
        test_bad_period;
        test_timeout;
        test_tolerance;
        test_mid_reset;
        test_acq_restart;
        test_duty;
        test_strobes;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
